// File: rtl/tlb_cam_array.sv
// Fully-associative TLB tag CAM: dual lookup ports, TLBP probe, Random/Wired replacement and a non-wired flush sweep.
// Optional multiple-match detection is built only when TLB_MULTIHIT_DET_EN is defined.
module tlb_cam_array #(
  parameter int ENTRIES = 32,
  parameter int IDX_W   = 5,
  parameter int ASID_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ASID_W-1:0] asid,
  input  logic [31:0]       i_vaddr,
  input  logic [31:0]       d_vaddr,
  output logic              i_hit,
  output logic              d_hit,
  output logic [IDX_W:0]    i_entry,
  output logic [IDX_W:0]    d_entry,
  output logic [15:0]       i_pagemask,
  output logic [15:0]       d_pagemask,
  input  logic              wr_req,
  input  logic              wr_random,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [15:0]       wr_pagemask,
  input  logic [18:0]       wr_vpn2,
  input  logic              wr_g,
  input  logic [ASID_W-1:0] wr_asid,
  input  logic              probe_req,
  input  logic [18:0]       probe_vpn2,
  input  logic [ASID_W-1:0] probe_asid,
  output logic              probe_done,
  output logic              probe_hit,
  output logic [IDX_W-1:0]  probe_index,
  input  logic [IDX_W-1:0]  wired,
  input  logic              wired_we,
  output logic [IDX_W-1:0]  random,
  input  logic              flush_req,
  output logic              busy,
  output logic              multi_hit
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(ENTRIES - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t             state;
  logic [IDX_W-1:0]   sweepIdx;
  logic [IDX_W-1:0]   wiredReg;
  logic [ENTRIES-1:0] valid;
  logic [ENTRIES-1:0] gArr;
  logic [15:0]        pmArr   [ENTRIES];
  logic [18:0]        vpnArr  [ENTRIES];
  logic [ASID_W-1:0]  asidArr [ENTRIES];

  logic [ENTRIES-1:0] iMatch, dMatch, pMatch;
  logic [IDX_W-1:0]   iIdx, dIdx, pIdx, wrIdx;
  logic               sweeping, iHitNext, dHitNext, pHitNext, wrEn;
  logic               unusedVa;

  // PageMask bits widen the page by masking the matching low VPN2 bits.
  function automatic logic camMatch(input logic [18:0] eVpn, input logic [15:0] ePm, input logic eG,
                                    input logic [ASID_W-1:0] eAsid, input logic [18:0] vpn,
                                    input logic [ASID_W-1:0] curAsid);
    return (((eVpn ^ vpn) & {3'b111, ~ePm}) == 19'd0) && (eG || (eAsid == curAsid));
  endfunction

  function automatic logic [IDX_W-1:0] lowIdx(input logic [ENTRIES-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int k = ENTRIES - 1; k >= 0; k--)
      if (m[k]) r = IDX_W'(k);
    return r;
  endfunction

  // Selects the VA bit just above the masked field: va[12] for 4K pages, va[14] for 16K, ...
  function automatic logic evenOdd(input logic [16:0] va, input logic [15:0] pm);
    return |(va & {pm, 1'b1} & {1'b1, ~pm});
  endfunction

  always_comb begin
    iMatch = '0;
    dMatch = '0;
    pMatch = '0;
    for (int k = 0; k < ENTRIES; k++) begin
      iMatch[k] = valid[k] && camMatch(vpnArr[k], pmArr[k], gArr[k], asidArr[k], i_vaddr[31:13], asid);
      dMatch[k] = valid[k] && camMatch(vpnArr[k], pmArr[k], gArr[k], asidArr[k], d_vaddr[31:13], asid);
      pMatch[k] = valid[k] && camMatch(vpnArr[k], pmArr[k], gArr[k], asidArr[k], probe_vpn2, probe_asid);
    end
  end

  assign iIdx     = lowIdx(iMatch);
  assign dIdx     = lowIdx(dMatch);
  assign pIdx     = lowIdx(pMatch);
  assign sweeping = (state == SWEEP);
  assign iHitNext = !sweeping && (|iMatch);
  assign dHitNext = !sweeping && (|dMatch);
  assign pHitNext = probe_req && !sweeping && (|pMatch);
  assign wrIdx    = wr_random ? random : wr_index;
  assign wrEn     = wr_req && !sweeping;
  assign unusedVa = ^{i_vaddr[11:0], d_vaddr[11:0]};

  always_ff @(posedge clk) begin
    if (wrEn) begin
      pmArr[wrIdx]   <= wr_pagemask;
      vpnArr[wrIdx]  <= wr_vpn2;
      asidArr[wrIdx] <= wr_asid;
      gArr[wrIdx]    <= wr_g;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid       <= '0;
      state       <= IDLE;
      busy        <= 1'b0;
      sweepIdx    <= LAST;
      wiredReg    <= '0;
      random      <= LAST;
      i_hit       <= 1'b0;
      d_hit       <= 1'b0;
      i_entry     <= '0;
      d_entry     <= '0;
      i_pagemask  <= '0;
      d_pagemask  <= '0;
      probe_done  <= 1'b0;
      probe_hit   <= 1'b0;
      probe_index <= '0;
    end else begin
      random <= (wired_we || (random <= wiredReg)) ? LAST : random - 1'b1;
      if (wired_we) wiredReg <= wired;

      i_hit       <= iHitNext;
      i_entry     <= iHitNext ? {iIdx, evenOdd(i_vaddr[28:12], pmArr[iIdx])} : '0;
      i_pagemask  <= iHitNext ? pmArr[iIdx] : '0;
      d_hit       <= dHitNext;
      d_entry     <= dHitNext ? {dIdx, evenOdd(d_vaddr[28:12], pmArr[dIdx])} : '0;
      d_pagemask  <= dHitNext ? pmArr[dIdx] : '0;
      probe_done  <= probe_req;
      probe_hit   <= pHitNext;
      probe_index <= pHitNext ? pIdx : '0;

      case (state)
        IDLE: begin
          if (wrEn) valid[wrIdx] <= 1'b1;
          if (flush_req) begin
            state    <= SWEEP;
            busy     <= 1'b1;
            sweepIdx <= LAST;
          end
        end
        SWEEP: begin
          valid[sweepIdx] <= 1'b0;
          if (sweepIdx <= wiredReg) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            sweepIdx <= sweepIdx - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TLB_MULTIHIT_DET_EN
  function automatic logic many(input logic [ENTRIES-1:0] m);
    return (m & (m - 1'b1)) != '0;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) multi_hit <= 1'b0;
    else     multi_hit <= !sweeping && (many(iMatch) || many(dMatch) || (probe_req && many(pMatch)));
  end
`else
  assign multi_hit = 1'b0;
`endif

endmodule

// File: tb/tb_tlb_cam_array.sv
// Scoreboard bench for tlb_cam_array: expectations are queued when stimulus is driven and popped when outputs are due.
module tb_tlb_cam_array;
`ifdef TLB_MULTIHIT_DET_EN
  localparam bit MH = 1'b1;
`else
  localparam bit MH = 1'b0;
`endif

  typedef struct packed {
    logic        iHit;
    logic [5:0]  iEntry;
    logic [15:0] iPm;
    logic        dHit;
    logic [5:0]  dEntry;
    logic [15:0] dPm;
  } lk_t;

  typedef struct packed {
    logic       done;
    logic       hit;
    logic [4:0] idx;
    logic       mh;
  } pr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  asid;
  logic [31:0] i_vaddr, d_vaddr;
  logic        i_hit, d_hit;
  logic [5:0]  i_entry, d_entry;
  logic [15:0] i_pagemask, d_pagemask;
  logic        wr_req, wr_random;
  logic [4:0]  wr_index;
  logic [15:0] wr_pagemask;
  logic [18:0] wr_vpn2;
  logic        wr_g;
  logic [7:0]  wr_asid;
  logic        probe_req;
  logic [18:0] probe_vpn2;
  logic [7:0]  probe_asid;
  logic        probe_done, probe_hit;
  logic [4:0]  probe_index;
  logic [4:0]  wired;
  logic        wired_we;
  logic [4:0]  random;
  logic        flush_req, busy, multi_hit;

  int  total = 0;
  int  bad   = 0;
  lk_t lkQ[$];
  pr_t prQ[$];

  tlb_cam_array dut (
    .clk(clk), .rst(rst), .asid(asid), .i_vaddr(i_vaddr), .d_vaddr(d_vaddr),
    .i_hit(i_hit), .d_hit(d_hit), .i_entry(i_entry), .d_entry(d_entry),
    .i_pagemask(i_pagemask), .d_pagemask(d_pagemask),
    .wr_req(wr_req), .wr_random(wr_random), .wr_index(wr_index), .wr_pagemask(wr_pagemask),
    .wr_vpn2(wr_vpn2), .wr_g(wr_g), .wr_asid(wr_asid),
    .probe_req(probe_req), .probe_vpn2(probe_vpn2), .probe_asid(probe_asid),
    .probe_done(probe_done), .probe_hit(probe_hit), .probe_index(probe_index),
    .wired(wired), .wired_we(wired_we), .random(random),
    .flush_req(flush_req), .busy(busy), .multi_hit(multi_hit)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic wr_entry(input logic [4:0] idx, input logic [18:0] vpn, input logic [7:0] a,
                          input logic g, input logic [15:0] pm);
    @(negedge clk);
    wr_req = 1'b1; wr_random = 1'b0; wr_index = idx; wr_vpn2 = vpn; wr_asid = a; wr_g = g; wr_pagemask = pm;
    @(negedge clk);
    wr_req = 1'b0;
  endtask

  task automatic set_wired(input logic [4:0] w);
    @(negedge clk);
    wired = w; wired_we = 1'b1;
    @(negedge clk);
    wired_we = 1'b0;
  endtask

  task automatic drive_lookup(input logic [7:0] a, input logic [31:0] iva, input logic [31:0] dva, input lk_t e);
    @(negedge clk);
    asid = a; i_vaddr = iva; d_vaddr = dva;
    lkQ.push_back(e);
  endtask

  task automatic test_reset;
    lk_t got, exp;
    rst = 1'b1;
    lkQ.push_back('0);
    repeat (2) @(negedge clk);
    got = {i_hit, i_entry, i_pagemask, d_hit, d_entry, d_pagemask};
    exp = lkQ.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL reset_lookup got=%h exp=%h", got, exp); end
    total++;
    if ({probe_done, probe_hit, busy, multi_hit} !== 4'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=0000", {probe_done, probe_hit, busy, multi_hit});
    end
    total++;
    if (random !== 5'd31) begin bad++; $display("FAIL reset_random got=%0d exp=31", random); end
    rst = 1'b0;
  endtask

  task automatic test_lookup;
    logic [7:0]  aTab [4];
    logic [31:0] iTab [4];
    logic [31:0] dTab [4];
    lk_t         eTab [4];
    lk_t         got, exp;
    wr_entry(5'd3, 19'h00010, 8'd5, 1'b0, 16'h0);
    wr_entry(5'd5, 19'h00040, 8'd9, 1'b1, 16'h0);
    aTab[0] = 8'd5; iTab[0] = 32'h0002_1000; dTab[0] = 32'h0002_0000; eTab[0] = {1'b1, 6'd7, 16'h0, 1'b1, 6'd6, 16'h0};
    aTab[1] = 8'd6; iTab[1] = 32'h0002_1000; dTab[1] = 32'h0008_0000; eTab[1] = {1'b0, 6'd0, 16'h0, 1'b1, 6'd10, 16'h0};
    aTab[2] = 8'd5; iTab[2] = 32'h0000_0000; dTab[2] = 32'h0008_1000; eTab[2] = {1'b0, 6'd0, 16'h0, 1'b1, 6'd11, 16'h0};
    aTab[3] = 8'd9; iTab[3] = 32'h0004_0000; dTab[3] = 32'h0002_0000; eTab[3] = '0;
    for (int k = 0; k < 4; k++) begin
      drive_lookup(aTab[k], iTab[k], dTab[k], eTab[k]);
      @(negedge clk);
      got = {i_hit, i_entry, i_pagemask, d_hit, d_entry, d_pagemask};
      exp = lkQ.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL lookup_%0d got=%h exp=%h", k, got, exp); end
    end
  endtask

  task automatic test_pagemask;
    logic [31:0] dTab [3];
    lk_t         eTab [3];
    lk_t         got, exp;
    wr_entry(5'd2, 19'h00100, 8'd5, 1'b0, 16'h0003);
    dTab[0] = 32'h0020_4000; eTab[0] = {1'b0, 6'd0, 16'h0, 1'b1, 6'd5, 16'h0003};
    dTab[1] = 32'h0020_0000; eTab[1] = {1'b0, 6'd0, 16'h0, 1'b1, 6'd4, 16'h0003};
    dTab[2] = 32'h0020_8000; eTab[2] = '0;
    for (int k = 0; k < 3; k++) begin
      drive_lookup(8'd5, 32'h0, dTab[k], eTab[k]);
      @(negedge clk);
      got = {i_hit, i_entry, i_pagemask, d_hit, d_entry, d_pagemask};
      exp = lkQ.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL pagemask_%0d got=%h exp=%h", k, got, exp); end
    end
  endtask

  task automatic test_write_bypass;
    lk_t got, exp;
    @(negedge clk);
    wr_req = 1'b1; wr_random = 1'b0; wr_index = 5'd8; wr_vpn2 = 19'h00500; wr_asid = 8'd5; wr_g = 1'b0; wr_pagemask = 16'h0;
    asid = 8'd5; i_vaddr = 32'h00A0_0000; d_vaddr = 32'h0;
    lkQ.push_back('0);
    lkQ.push_back({1'b1, 6'd16, 16'h0, 1'b0, 6'd0, 16'h0});
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      wr_req = 1'b0;
      got = {i_hit, i_entry, i_pagemask, d_hit, d_entry, d_pagemask};
      exp = lkQ.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL write_bypass_%0d got=%h exp=%h", k, got, exp); end
    end
  endtask

  task automatic test_back_to_back_probe;
    logic [18:0] vTab [3];
    logic [7:0]  aTab [3];
    pr_t         eTab [3];
    pr_t         got, exp;
    wr_entry(5'd1, 19'h00300, 8'd7, 1'b0, 16'h0);
    wr_entry(5'd6, 19'h00300, 8'd7, 1'b0, 16'h0);
    asid = 8'd0; i_vaddr = 32'h0; d_vaddr = 32'h0;
    vTab[0] = 19'h00300; aTab[0] = 8'd7; eTab[0] = {1'b1, 1'b1, 5'd1, MH};
    vTab[1] = 19'h00010; aTab[1] = 8'd5; eTab[1] = {1'b1, 1'b1, 5'd3, 1'b0};
    vTab[2] = 19'h00999; aTab[2] = 8'd7; eTab[2] = {1'b1, 1'b0, 5'd0, 1'b0};
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      if (k > 0) begin
        got = {probe_done, probe_hit, probe_index, multi_hit};
        exp = prQ.pop_front();
        total++;
        if (got !== exp) begin bad++; $display("FAIL probe_%0d got=%b exp=%b", k - 1, got, exp); end
      end
      if (k < 3) begin
        probe_req = 1'b1; probe_vpn2 = vTab[k]; probe_asid = aTab[k];
        prQ.push_back(eTab[k]);
      end else begin
        probe_req = 1'b0;
      end
    end
    @(negedge clk);
    total++;
    if (probe_done !== 1'b0) begin bad++; $display("FAIL probe_idle got=%b exp=0", probe_done); end
  endtask

  task automatic test_random;
    logic [4:0] exp;
    bit         found;
    lk_t        got, lexp;
    set_wired(5'd4);
    exp = 5'd31;
    for (int k = 0; k < 30; k++) begin
      total++;
      if (random !== exp) begin bad++; $display("FAIL random_seq_%0d got=%0d exp=%0d", k, random, exp); end
      exp = (exp <= 5'd4) ? 5'd31 : exp - 5'd1;
      @(negedge clk);
    end
    found = 1'b0;
    for (int k = 0; k < 64 && !found; k++) begin
      @(negedge clk);
      if (random == 5'd9) found = 1'b1;
    end
    total++;
    if (!found) begin bad++; $display("FAIL random_reach9 got=%0d exp=9", random); end
    wr_req = 1'b1; wr_random = 1'b1; wr_index = 5'd0; wr_vpn2 = 19'h00600; wr_asid = 8'd5; wr_g = 1'b0; wr_pagemask = 16'h0;
    @(negedge clk);
    wr_req = 1'b0; wr_random = 1'b0;
    drive_lookup(8'd5, 32'h00C0_0000, 32'h0, {1'b1, 6'd18, 16'h0, 1'b0, 6'd0, 16'h0});
    @(negedge clk);
    got  = {i_hit, i_entry, i_pagemask, d_hit, d_entry, d_pagemask};
    lexp = lkQ.pop_front();
    total++;
    if (got !== lexp) begin bad++; $display("FAIL random_write got=%h exp=%h", got, lexp); end
  endtask

  task automatic test_flush;
    int          cnt;
    bit          done;
    logic [7:0]  aTab [3];
    logic [31:0] iTab [3];
    logic [31:0] dTab [3];
    lk_t         eTab [3];
    lk_t         got, exp;
    set_wired(5'd2);
    wr_entry(5'd0, 19'h00700, 8'd5, 1'b0, 16'h0);
    @(negedge clk);
    flush_req = 1'b1;
    cnt = 0; done = 1'b0;
    for (int g = 0; g < 100 && !done; g++) begin
      @(negedge clk);
      flush_req = 1'b0;
      if (!busy) done = 1'b1;
      else begin
        cnt++;
        if (cnt == 1) begin
          wr_req = 1'b1; wr_random = 1'b0; wr_index = 5'd1; wr_vpn2 = 19'h007FF; wr_asid = 8'd7; wr_g = 1'b0; wr_pagemask = 16'h0;
          asid = 8'd7; i_vaddr = 32'h0060_0000; d_vaddr = 32'h0;
        end
        if (cnt == 2) begin
          wr_req = 1'b0;
          total++;
          if (i_hit !== 1'b0) begin bad++; $display("FAIL sweep_lookup got=%b exp=0", i_hit); end
        end
      end
    end
    total++;
    if (cnt != 30) begin bad++; $display("FAIL flush_busy_cycles got=%0d exp=30", cnt); end
    aTab[0] = 8'd7; iTab[0] = 32'h0060_0000; dTab[0] = 32'h0008_0000; eTab[0] = {1'b1, 6'd2, 16'h0, 1'b0, 6'd0, 16'h0};
    aTab[1] = 8'd5; iTab[1] = 32'h00E0_0000; dTab[1] = 32'h0002_1000; eTab[1] = {1'b1, 6'd0, 16'h0, 1'b0, 6'd0, 16'h0};
    aTab[2] = 8'd5; iTab[2] = 32'h00C0_0000; dTab[2] = 32'h00A0_0000; eTab[2] = '0;
    for (int k = 0; k < 3; k++) begin
      drive_lookup(aTab[k], iTab[k], dTab[k], eTab[k]);
      @(negedge clk);
      got = {i_hit, i_entry, i_pagemask, d_hit, d_entry, d_pagemask};
      exp = lkQ.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL post_flush_%0d got=%h exp=%h", k, got, exp); end
    end
  endtask

  task automatic test_write_flush;
    int  cnt;
    bit  done;
    lk_t got, exp;
    set_wired(5'd12);
    @(negedge clk);
    wr_req = 1'b1; wr_random = 1'b0; wr_index = 5'd10; wr_vpn2 = 19'h00800; wr_asid = 8'd5; wr_g = 1'b0; wr_pagemask = 16'h0;
    flush_req = 1'b1;
    @(negedge clk);
    wr_req = 1'b0; flush_req = 1'b0;
    cnt = busy ? 1 : 0;
    done = 1'b0;
    for (int g = 0; g < 100 && !done; g++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
      else cnt++;
    end
    total++;
    if (cnt != 20) begin bad++; $display("FAIL write_flush_busy got=%0d exp=20", cnt); end
    drive_lookup(8'd5, 32'h0100_0000, 32'h0, {1'b1, 6'd20, 16'h0, 1'b0, 6'd0, 16'h0});
    @(negedge clk);
    got = {i_hit, i_entry, i_pagemask, d_hit, d_entry, d_pagemask};
    exp = lkQ.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL write_before_flush got=%h exp=%h", got, exp); end
  endtask

  task automatic test_reset_mid_sweep;
    int  cnt;
    lk_t got, exp;
    @(negedge clk);
    flush_req = 1'b1;
    cnt = 0;
    for (int g = 0; g < 100 && cnt < 5; g++) begin
      @(negedge clk);
      flush_req = 1'b0;
      if (busy) cnt++;
    end
    total++;
    if (cnt != 5) begin bad++; $display("FAIL sweep_start got=%0d exp=5", cnt); end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, random} !== {1'b0, 5'd31}) begin
      bad++; $display("FAIL rst_mid_sweep busy=%b random=%0d exp busy=0 random=31", busy, random);
    end
    rst = 1'b0;
    drive_lookup(8'd5, 32'h0100_0000, 32'h00E0_0000, '0);
    @(negedge clk);
    got = {i_hit, i_entry, i_pagemask, d_hit, d_entry, d_pagemask};
    exp = lkQ.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL rst_clears_a got=%h exp=%h", got, exp); end
    drive_lookup(8'd7, 32'h0060_0000, 32'h0002_1000, '0);
    @(negedge clk);
    got = {i_hit, i_entry, i_pagemask, d_hit, d_entry, d_pagemask};
    exp = lkQ.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL rst_clears_b got=%h exp=%h", got, exp); end
  endtask

  initial begin
    rst = 1'b1; asid = '0; i_vaddr = '0; d_vaddr = '0;
    wr_req = 1'b0; wr_random = 1'b0; wr_index = '0; wr_pagemask = '0; wr_vpn2 = '0; wr_g = 1'b0; wr_asid = '0;
    probe_req = 1'b0; probe_vpn2 = '0; probe_asid = '0;
    wired = '0; wired_we = 1'b0; flush_req = 1'b0;
    test_reset();
    test_lookup();
    test_pagemask();
    test_write_bypass();
    test_back_to_back_probe();
    test_random();
    test_flush();
    test_write_flush();
    test_reset_mid_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
